instruction_fetch_unit: RTL and testbench

Fetch stage of the RV32I pipeline: holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It sits between the hazard/branch logic (EX stage) and the decode stage. It supports stall, flush and branch/jump redirect, and flags misaligned redirect targets.

---
 rtl/instruction_fetch_unit.sv | 66 ++++++
 tb/tb_instruction_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC register, instruction-memory address drive and IF/ID pipeline register.
// Supports stall, flush and branch/jump redirect, and flags misaligned redirect targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] ReadInstruction,
  output logic [31:0] InstructionAddress,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        MisalignedFetch,
  output logic [31:0] FetchCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4           = pc + 32'd4;
  assign InstructionAddress = pc;

  // Priority: redirect over stall (redirecting instruction is older), stall over flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc                <= RESET_VECTOR;
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_PC          <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Valid       <= 1'b0;
      MisalignedFetch   <= 1'b0;
      FetchCount        <= '0;
    end else if (BranchTaken) begin
      pc                <= {BranchTarget[31:2], 2'b00};
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_PC          <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Valid       <= 1'b0;
      MisalignedFetch   <= (BranchTarget[1:0] != 2'b00);
    end else if (Stall) begin
      MisalignedFetch   <= 1'b0;
    end else if (Flush) begin
      pc                <= pc_plus4;
      IF_ID_Instruction <= NOP_INSTR;
      IF_ID_PC          <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Valid       <= 1'b0;
      MisalignedFetch   <= 1'b0;
    end else begin
      pc                <= pc_plus4;
      IF_ID_Instruction <= ReadInstruction;
      IF_ID_PC          <= pc;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
      MisalignedFetch   <= 1'b0;
      FetchCount        <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table of vectors with hand-derived
// expectations fed through a scoreboard queue, plus an async-reset-mid-stall sequence.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, Flush, BranchTaken;
  logic [31:0] BranchTarget, ReadInstruction;
  logic [31:0] InstructionAddress, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4, FetchCount;
  logic        IF_ID_Valid, MisalignedFetch;

  instruction_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .ReadInstruction   (ReadInstruction),
    .InstructionAddress(InstructionAddress),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .MisalignedFetch   (MisalignedFetch),
    .FetchCount        (FetchCount)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory model: three known words, a distinct pattern elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem = 32'h0050_0093;
      32'h0000_0004: imem = 32'h00A0_0113;
      32'h0000_0008: imem = 32'h0020_81B3;
      default:       imem = a ^ 32'hDEAD_0000;
    endcase
  endfunction

  always_comb ReadInstruction = imem(InstructionAddress);

  typedef struct {
    logic        stall, flush, bt;
    logic [31:0] tgt;
    logic [31:0] pc, instr, ifpc, ifpc4;
    logic        valid, mis;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr, ifpc, ifpc4;
    logic        valid, mis;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".pc"},    InstructionAddress, e.pc);
    check({tag, ".instr"}, IF_ID_Instruction,  e.instr);
    check({tag, ".ifpc"},  IF_ID_PC,           e.ifpc);
    check({tag, ".ifpc4"}, IF_ID_PCPlus4,      e.ifpc4);
    check({tag, ".valid"}, {31'd0, IF_ID_Valid},     {31'd0, e.valid});
    check({tag, ".mis"},   {31'd0, MisalignedFetch}, {31'd0, e.mis});
    check({tag, ".cnt"},   FetchCount,         e.cnt);
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ip,
                              input logic [31:0] ip4, input logic v, input logic m,
                              input logic [31:0] c);
    vec_t r;
    r.stall = s; r.flush = f; r.bt = b; r.tgt = t;
    r.pc = pc; r.instr = ins; r.ifpc = ip; r.ifpc4 = ip4; r.valid = v; r.mis = m; r.cnt = c;
    return r;
  endfunction

  // Drive one vector at the negedge, push its expectation, compare #1 after the next posedge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    e.pc = v.pc; e.instr = v.instr; e.ifpc = v.ifpc; e.ifpc4 = v.ifpc4;
    e.valid = v.valid; e.mis = v.mis; e.cnt = v.cnt;
    Stall = v.stall; Flush = v.flush; BranchTaken = v.bt; BranchTarget = v.tgt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
    end else begin
      compare_outputs(tag, sb.pop_front());
    end
    @(negedge clk);
  endtask

  exp_t rst_exp;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_exp.pc = 32'h0; rst_exp.instr = NOP; rst_exp.ifpc = 32'h0; rst_exp.ifpc4 = 32'h0;
    rst_exp.valid = 1'b0; rst_exp.mis = 1'b0; rst_exp.cnt = 32'h0;

    //                  st fl bt target          pc             instr                ifpc           ifpc4          v  m  cnt
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h4,         32'h0050_0093,       32'h0,         32'h4,         1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h8,         32'h00A0_0113,       32'h4,         32'h8,         1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,          32'h8,         32'h00A0_0113,       32'h4,         32'h8,         1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 32'h0,          32'h8,         32'h00A0_0113,       32'h4,         32'h8,         1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'hC,         32'h0020_81B3,       32'h8,         32'hC,         1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h10,        imem(32'hC),         32'hC,         32'h10,        1, 0, 4));
    vecs.push_back(mk(0, 1, 0, 32'h0,          32'h14,        NOP,                 32'h0,         32'h0,         0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h18,        imem(32'h14),        32'h14,        32'h18,        1, 0, 5));
    vecs.push_back(mk(1, 1, 0, 32'h0,          32'h18,        imem(32'h14),        32'h14,        32'h18,        1, 0, 5));
    vecs.push_back(mk(1, 0, 1, 32'h40,         32'h40,        NOP,                 32'h0,         32'h0,         0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h44,        imem(32'h40),        32'h40,        32'h44,        1, 0, 6));
    vecs.push_back(mk(0, 0, 1, 32'h22,         32'h20,        NOP,                 32'h0,         32'h0,         0, 1, 6));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h24,        imem(32'h20),        32'h20,        32'h24,        1, 0, 7));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, NOP,                 32'h0,         32'h0,         0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 32'h0,          32'h0,         imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,         1, 0, 8));
    vecs.push_back(mk(0, 0, 1, 32'h41,         32'h40,        NOP,                 32'h0,         32'h0,         0, 1, 8));
    vecs.push_back(mk(1, 0, 0, 32'h0,          32'h40,        NOP,                 32'h0,         32'h0,         0, 0, 8));
    vecs.push_back(mk(1, 0, 0, 32'h0,          32'h40,        NOP,                 32'h0,         32'h0,         0, 0, 8));

    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    #1;
    compare_outputs("reset", rst_exp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Async reset asserted between edges while stalled: outputs clear before any edge.
    Stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    compare_outputs("async_rst", rst_exp);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0, 0, 0, 32'h0, 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 1), "post_rst");

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
